// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters. Each operation runs IDLE (grant/latch) -> EXEC (ALU driven)
// -> RESP (result held until the owner accepts it).
// Optional feature macro: ALU_ARB_ILLEGAL_CHK_EN -- flags opcodes above 11,
// keeps the ALU idle for them and returns a zero result with rsp_err set.
module alu_share_arb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shamt,
  input  logic              req0_bsel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shamt,
  input  logic              req1_bsel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_data_A,
  output logic [DATA_W-1:0] alu_data_B,
  output logic [4:0]        alu_shamt,
  output logic [3:0]        alu_sel,
  output logic              alu_B_sel,
  input  logic [DATA_W-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last;
  logic              owner;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [4:0]        shamt_q;
  logic              bsel_q;
  logic [DATA_W-1:0] result_q;

  logic grant_valid;
  logic grant;
  logic sel_illegal;
  logic exec_drive;
  logic owner_ready;

  // Round-robin grant: a lone requester wins, under contention the port
  // that was not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant       = ~last;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && grant_valid && (grant == 1'b0);
  assign req1_ready = (state == IDLE) && grant_valid && (grant == 1'b1);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic err_q;
  assign sel_illegal = (sel_q > 4'd11);
`else
  assign sel_illegal = 1'b0;
`endif

  // The ALU only sees the latched operands during EXEC; otherwise all zero.
  assign exec_drive = (state == EXEC) && !sel_illegal;
  assign alu_data_A = exec_drive ? a_q     : '0;
  assign alu_data_B = exec_drive ? b_q     : '0;
  assign alu_shamt  = exec_drive ? shamt_q : 5'd0;
  assign alu_sel    = exec_drive ? sel_q   : 4'd0;
  assign alu_B_sel  = exec_drive ? bsel_q  : 1'b0;

  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == RESP) && (owner == 1'b0);
  assign rsp1_valid = (state == RESP) && (owner == 1'b1);
  assign rsp0_data  = rsp0_valid ? result_q : '0;
  assign rsp1_data  = rsp1_valid ? result_q : '0;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign rsp0_err = rsp0_valid && err_q;
  assign rsp1_err = rsp1_valid && err_q;
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  // Sequencer: latch the granted request, capture the ALU result, hold it
  // until the owner takes it, then hand priority to the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      sel_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= 5'd0;
      bsel_q   <= 1'b0;
      result_q <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant;
            sel_q   <= grant ? req1_sel   : req0_sel;
            a_q     <= grant ? req1_a     : req0_a;
            b_q     <= grant ? req1_b     : req0_b;
            shamt_q <= grant ? req1_shamt : req0_shamt;
            bsel_q  <= grant ? req1_bsel  : req0_bsel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          result_q <= sel_illegal ? '0 : alu_out;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
          err_q    <= sel_illegal;
`endif
          state    <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            last  <= owner;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            err_q <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a small ALU model
// attached to the ALU-side ports. Honors ALU_ARB_ILLEGAL_CHK_EN if defined.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        req0_bsel, req1_bsel;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [31:0] alu_data_A, alu_data_B, alu_out;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_sel;
  logic        alu_B_sel;

  int checkCount;
  int failCount;

  alu_share_arb #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_bsel(req0_bsel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_bsel(req1_bsel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_data_A(alu_data_A), .alu_data_B(alu_data_B), .alu_shamt(alu_shamt),
    .alu_sel(alu_sel), .alu_B_sel(alu_B_sel), .alu_out(alu_out)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU standing in for the shared combinational unit
  always_comb begin
    logic [4:0] sh;
    sh = alu_B_sel ? alu_shamt : alu_data_B[4:0];
    case (alu_sel)
      4'd0:  alu_out = alu_data_A + alu_data_B;
      4'd1:  alu_out = alu_data_A - alu_data_B;
      4'd2:  alu_out = alu_data_A ^ alu_data_B;
      4'd3:  alu_out = alu_data_A | alu_data_B;
      4'd4:  alu_out = alu_data_A & alu_data_B;
      4'd5:  alu_out = alu_data_A << sh;
      4'd6:  alu_out = alu_data_A >> sh;
      4'd7:  alu_out = $unsigned($signed(alu_data_A) >>> sh);
      4'd8:  alu_out = {31'd0, $signed(alu_data_A) < $signed(alu_data_B)};
      4'd9:  alu_out = {31'd0, alu_data_A < alu_data_B};
      4'd10: alu_out = alu_data_B;
      4'd11: alu_out = alu_data_A + alu_data_B;
      default: alu_out = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] shamt, input logic bsel);
    if (port == 0) begin
      req0_sel = sel; req0_a = a; req0_b = b; req0_shamt = shamt; req0_bsel = bsel;
      req0_valid = 1'b1;
    end else begin
      req1_sel = sel; req1_a = a; req1_b = b; req1_shamt = shamt; req1_bsel = bsel;
      req1_valid = 1'b1;
    end
  endtask

  // Wait (bounded) for the port's grant, take the handshake edge, drop valid.
  task automatic grantAndLaunch(input int port);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) got = 1'b1;
    end
    checkOutput("grant_wait", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic runOp(input int port, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] shamt, input logic bsel,
                       input logic [31:0] expData, input logic expErr,
                       input logic [3:0] expAluSel, input logic [31:0] expAluA);
    applyStimulus(port, sel, a, b, shamt, bsel);
    grantAndLaunch(port);
    checkOutput("exec_alu_sel", {28'd0, alu_sel}, {28'd0, expAluSel});
    checkOutput("exec_alu_a", alu_data_A, expAluA);
    checkOutput("exec_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    @(posedge clk); #1;
    if (port == 0) begin
      checkOutput("rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      checkOutput("rsp0_data", rsp0_data, expData);
      checkOutput("rsp0_err", {31'd0, rsp0_err}, {31'd0, expErr});
      checkOutput("rsp1_idle", {31'd0, rsp1_valid}, 32'd0);
      rsp0_ready = 1'b1;
    end else begin
      checkOutput("rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      checkOutput("rsp1_data", rsp1_data, expData);
      checkOutput("rsp1_err", {31'd0, rsp1_err}, {31'd0, expErr});
      checkOutput("rsp0_idle", {31'd0, rsp0_valid}, 32'd0);
      rsp1_ready = 1'b1;
    end
    checkOutput("resp_alu_sel", {28'd0, alu_sel}, 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    checkOutput("rsp_released", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    checkOutput("rsp_data_zero", rsp0_data | rsp1_data, 32'd0);
  endtask

  // Directed scenario sequence
  initial begin
    int   got;
    logic [31:0] expD;
    checkCount = 0;
    failCount  = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = 4'd0; req0_a = '0; req0_b = '0; req0_shamt = 5'd0; req0_bsel = 1'b0;
    req1_sel = 4'd0; req1_a = '0; req1_b = '0; req1_shamt = 5'd0; req1_bsel = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    #3;
    checkOutput("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    checkOutput("reset_alu", alu_data_A | alu_data_B | {27'd0, alu_shamt} | {28'd0, alu_sel} | {31'd0, alu_B_sel}, 32'd0);
    checkOutput("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single request add 5+7");
    runOp(0, 4'd0, 32'd5, 32'd7, 5'd0, 1'b0, 32'd12, 1'b0, 4'd0, 32'd5);

    $display("[TB] backpressure xor on port 1");
    applyStimulus(1, 4'd2, 32'hFF, 32'h0F, 5'd0, 1'b0);
    grantAndLaunch(1);
    @(posedge clk); #1;
    applyStimulus(0, 4'd0, 32'd1, 32'd1, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      checkOutput("bp_rsp1_data", rsp1_data, 32'hF0);
      checkOutput("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
    end
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_req0_after", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] contention, strict alternation");
    applyStimulus(0, 4'd1, 32'd10, 32'd3, 5'd0, 1'b0);
    applyStimulus(1, 4'd7, 32'h80000000, 32'd0, 5'd4, 1'b1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int i = 0; i < 10 && got < 0; i++) begin
        @(negedge clk);
        if (req0_ready) got = 0;
        else if (req1_ready) got = 1;
      end
      checkOutput("arb_order", got, k % 2);
      @(posedge clk);
      @(posedge clk); #1;
      expD = (k % 2 == 0) ? 32'd7 : 32'hF8000000;
      checkOutput("arb_rsp_data", (k % 2 == 0) ? rsp0_data : rsp1_data, expD);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] slt / sltu");
    runOp(0, 4'd8, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 32'd1, 1'b0, 4'd8, 32'hFFFFFFFF);
    runOp(1, 4'd9, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 32'd0, 1'b0, 4'd9, 32'hFFFFFFFF);

    $display("[TB] opcode 13 on port 1");
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    runOp(1, 4'd13, 32'd9, 32'd4, 5'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'd0);
`else
    runOp(1, 4'd13, 32'd9, 32'd4, 5'd0, 1'b0, 32'd0, 1'b0, 4'd13, 32'd9);
`endif

    $display("[TB] reset during EXEC");
    applyStimulus(0, 4'd3, 32'h1234, 32'h0F00, 5'd0, 1'b0);
    grantAndLaunch(0);
    checkOutput("pre_reset_alu_a", alu_data_A, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_alu_a", alu_data_A, 32'd0);
    checkOutput("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    checkOutput("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    rsp0_ready = 1'b0;
    applyStimulus(0, 4'd0, 32'd1, 32'd1, 5'd0, 1'b0);
    applyStimulus(1, 4'd0, 32'd2, 32'd2, 5'd0, 1'b0);
    #1;
    checkOutput("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    runOp(0, 4'd0, 32'd1, 32'd1, 5'd0, 1'b0, 32'd2, 1'b0, 4'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
